// File: rtl/nios2_mul_combine.sv
// nios2_mul_combine
// Combines the three 16x16 partial products of a 32x32 multiply into the low
// 32 bits of the product. Optional cross-sum register stage (S1) ahead of the
// output stage (S2); valid/ready on both sides, tag carried with each op,
// synchronous flush kills everything in flight.
module nios2_mul_combine #(
  parameter int TAG_W = 5,
  parameter int S1_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_p1,
  input  logic [31:0]      in_p2,
  input  logic [31:0]      in_p3,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam bit USE_S1 = (S1_EN != 0);

  logic             s1_valid_q,   s1_valid_d;
  logic [31:0]      s1_p1_q,      s1_p1_d;
  logic [15:0]      s1_cross_q,   s1_cross_d;
  logic [TAG_W-1:0] s1_tag_q,     s1_tag_d;
  logic             out_valid_q,  out_valid_d;
  logic [31:0]      out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q,    out_tag_d;

  logic        s2_free;
  logic        s1_free;
  logic        accept;
  logic        s1_move;
  logic [15:0] in_cross;

  // Upper halves of the cross products only affect bits above 31.
  logic unused_hi;
  assign unused_hi = ^{in_p2[31:16], in_p3[31:16]};

  // Handshake: a stage is free when empty or when its contents leave this cycle.
  always_comb begin
    s2_free  = ~out_valid_q | out_ready;
    s1_free  = ~s1_valid_q | s2_free;
    in_ready = (USE_S1 ? s1_free : s2_free) & ~flush & ~reset;
    accept   = in_valid & in_ready;
    s1_move  = USE_S1 & s1_valid_q & s2_free & ~flush;
    in_cross = in_p2[15:0] + in_p3[15:0];
  end

  // Next-state: data registers load only on a transfer; flush clears valids only.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_p1_d      = s1_p1_q;
    s1_cross_d   = s1_cross_q;
    s1_tag_d     = s1_tag_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;

    if (USE_S1) begin
      if (accept) begin
        s1_valid_d = 1'b1;
        s1_p1_d    = in_p1;
        s1_cross_d = in_cross;
        s1_tag_d   = in_tag;
      end else if (s1_move) begin
        s1_valid_d = 1'b0;
      end
      if (s1_move) begin
        out_valid_d  = 1'b1;
        out_result_d = s1_p1_q + {s1_cross_q, 16'h0000};
        out_tag_d    = s1_tag_q;
      end else if (s2_free) begin
        out_valid_d = 1'b0;
      end
    end else begin
      if (accept) begin
        out_valid_d  = 1'b1;
        out_result_d = in_p1 + {in_cross, 16'h0000};
        out_tag_d    = in_tag;
      end else if (s2_free) begin
        out_valid_d = 1'b0;
      end
    end

    if (flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset that clears valids and data alike.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_p1_q      <= '0;
      s1_cross_q   <= '0;
      s1_tag_q     <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_p1_q      <= s1_p1_d;
      s1_cross_q   <= s1_cross_d;
      s1_tag_q     <= s1_tag_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

endmodule
